// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 INCR burst master: one command drives either a write
// burst fed from the wr_* stream or a read burst returned on the rd_* stream.
module axi4_burst_master #(
  parameter int unsigned AXI4_ID_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MASTER_ID     = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [7:0]                cmd_len,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic                      rd_last,
  input  logic                      rd_ready,
  output logic                      done,
  output logic                      err,
  output logic [AXI4_ID_WIDTH-1:0]  M_AXI4_AWID,
  output logic [ADDR_WIDTH-1:0]     M_AXI4_AWADDR,
  output logic [7:0]                M_AXI4_AWLEN,
  output logic [2:0]                M_AXI4_AWSIZE,
  output logic [1:0]                M_AXI4_AWBURST,
  output logic                      M_AXI4_AWVALID,
  input  logic                      M_AXI4_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI4_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI4_WSTRB,
  output logic                      M_AXI4_WLAST,
  output logic                      M_AXI4_WVALID,
  input  logic                      M_AXI4_WREADY,
  input  logic [AXI4_ID_WIDTH-1:0]  M_AXI4_BID,
  input  logic [1:0]                M_AXI4_BRESP,
  input  logic                      M_AXI4_BVALID,
  output logic                      M_AXI4_BREADY,
  output logic [AXI4_ID_WIDTH-1:0]  M_AXI4_ARID,
  output logic [ADDR_WIDTH-1:0]     M_AXI4_ARADDR,
  output logic [7:0]                M_AXI4_ARLEN,
  output logic [2:0]                M_AXI4_ARSIZE,
  output logic [1:0]                M_AXI4_ARBURST,
  output logic                      M_AXI4_ARVALID,
  input  logic                      M_AXI4_ARREADY,
  input  logic [AXI4_ID_WIDTH-1:0]  M_AXI4_RID,
  input  logic [DATA_WIDTH-1:0]     M_AXI4_RDATA,
  input  logic [1:0]                M_AXI4_RRESP,
  input  logic                      M_AXI4_RLAST,
  input  logic                      M_AXI4_RVALID,
  output logic                      M_AXI4_RREADY
);

  localparam int unsigned SPAN_W = 14;
  localparam logic [AXI4_ID_WIDTH-1:0] OWN_ID = AXI4_ID_WIDTH'(MASTER_ID);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;

  logic [SPAN_W-1:0]       span_end_c;
  logic                    cmd_bad_c;
  logic                    last_beat_c;
  logic                    w_hs_c;
  logic                    r_hs_c;

  // Burst end offset within the 4KB page; anything past 4096 crosses it.
  assign span_end_c  = SPAN_W'(cmd_addr[11:0]) + SPAN_W'({cmd_len, 2'b00}) + SPAN_W'(4);
  assign cmd_bad_c   = (cmd_addr[1:0] != 2'b00) || (span_end_c > SPAN_W'(4096));
  assign last_beat_c = (cnt_q == len_q);
  assign w_hs_c      = M_AXI4_WVALID && M_AXI4_WREADY;
  assign r_hs_c      = M_AXI4_RVALID && M_AXI4_RREADY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          cnt_d  = '0;
          err_d  = 1'b0;
          if (cmd_bad_c) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = cmd_write ? WR_ADDR : RD_ADDR;
          end
        end
      end
      WR_ADDR: if (M_AXI4_AWREADY) state_d = WR_DATA;
      WR_DATA: begin
        if (w_hs_c) begin
          cnt_d = cnt_q + 8'd1;
          if (last_beat_c) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (M_AXI4_BVALID) begin
          if ((M_AXI4_BRESP != 2'b00) || (M_AXI4_BID != OWN_ID)) err_d = 1'b1;
          state_d = DONE;
        end
      end
      RD_ADDR: if (M_AXI4_ARREADY) state_d = RD_DATA;
      RD_DATA: begin
        // RLAST must coincide with the len-th beat; either mismatch is an error.
        if (r_hs_c) begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if ((M_AXI4_RRESP != 2'b00) || (M_AXI4_RID != OWN_ID) ||
              (M_AXI4_RLAST != last_beat_c)) err_d = 1'b1;
          if (M_AXI4_RLAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready      = (state_q == IDLE);
  assign done           = (state_q == DONE);
  assign err            = err_q;

  assign M_AXI4_AWID    = OWN_ID;
  assign M_AXI4_AWADDR  = addr_q;
  assign M_AXI4_AWLEN   = len_q;
  assign M_AXI4_AWSIZE  = 3'b010;
  assign M_AXI4_AWBURST = 2'b01;
  assign M_AXI4_AWVALID = (state_q == WR_ADDR);

  // Write data streams straight through while in WR_DATA.
  assign M_AXI4_WDATA   = wr_data;
  assign M_AXI4_WSTRB   = '1;
  assign M_AXI4_WVALID  = (state_q == WR_DATA) && wr_valid;
  assign M_AXI4_WLAST   = (state_q == WR_DATA) && last_beat_c;
  assign wr_ready       = (state_q == WR_DATA) && M_AXI4_WREADY;
  assign M_AXI4_BREADY  = (state_q == WR_RESP);

  assign M_AXI4_ARID    = OWN_ID;
  assign M_AXI4_ARADDR  = addr_q;
  assign M_AXI4_ARLEN   = len_q;
  assign M_AXI4_ARSIZE  = 3'b010;
  assign M_AXI4_ARBURST = 2'b01;
  assign M_AXI4_ARVALID = (state_q == RD_ADDR);

  assign M_AXI4_RREADY  = (state_q == RD_DATA) && rd_ready;
  assign rd_valid       = (state_q == RD_DATA) && M_AXI4_RVALID;
  assign rd_data        = M_AXI4_RDATA;
  assign rd_last        = (state_q == RD_DATA) && M_AXI4_RLAST;

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master with an inline AXI slave model per command.
module tb_axi4_burst_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_last, rd_ready;
  logic        done, err;
  logic [3:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi4_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .done(done), .err(err),
    .M_AXI4_AWID(awid), .M_AXI4_AWADDR(awaddr), .M_AXI4_AWLEN(awlen),
    .M_AXI4_AWSIZE(awsize), .M_AXI4_AWBURST(awburst), .M_AXI4_AWVALID(awvalid),
    .M_AXI4_AWREADY(awready),
    .M_AXI4_WDATA(wdata), .M_AXI4_WSTRB(wstrb), .M_AXI4_WLAST(wlast),
    .M_AXI4_WVALID(wvalid), .M_AXI4_WREADY(wready),
    .M_AXI4_BID(bid), .M_AXI4_BRESP(bresp), .M_AXI4_BVALID(bvalid), .M_AXI4_BREADY(bready),
    .M_AXI4_ARID(arid), .M_AXI4_ARADDR(araddr), .M_AXI4_ARLEN(arlen),
    .M_AXI4_ARSIZE(arsize), .M_AXI4_ARBURST(arburst), .M_AXI4_ARVALID(arvalid),
    .M_AXI4_ARREADY(arready),
    .M_AXI4_RID(rid), .M_AXI4_RDATA(rdata), .M_AXI4_RRESP(rresp), .M_AXI4_RLAST(rlast),
    .M_AXI4_RVALID(rvalid), .M_AXI4_RREADY(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input int aw_delay, input bit gaps, input logic [1:0] resp,
                          input bit exp_err, input bit exp_traffic);
    int aw_hs = 0, w_beats = 0, aw_wait = 0, cyc = 0;
    bit b_done = 0, got_done = 0, done_err = 0, traffic = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len;
    #1 chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!got_done && cyc < 300) begin
      awready  = (aw_wait >= aw_delay);
      wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wready   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_data  = 32'hA0 + 32'(w_beats);
      bvalid   = (w_beats == int'(len) + 1) && !b_done;
      bresp    = resp;
      #1;
      if (awvalid || arvalid || wvalid) traffic = 1;
      if (awvalid) begin
        chk({tag, ".awaddr"}, awaddr, addr);
        chk({tag, ".aw_fields"}, 32'({awid, awlen, awsize, awburst, wstrb}),
            32'({4'd0, len, 3'b010, 2'b01, 4'hF}));
        if (awready) aw_hs++; else aw_wait++;
      end
      if (wvalid && wready) begin
        chk({tag, ".wdata"}, wdata, 32'hA0 + 32'(w_beats));
        chk({tag, ".wlast"}, 32'(wlast), 32'(w_beats == int'(len)));
        chk({tag, ".wr_ready"}, 32'(wr_ready), 32'd1);
        w_beats++;
      end
      if (bvalid && bready) b_done = 1;
      if (done) begin got_done = 1; done_err = err; end
      cyc++;
      if (!got_done) @(negedge clk);
    end
    idle_inputs();
    chk({tag, ".done_seen"}, 32'(got_done), 32'd1);
    chk({tag, ".err"}, 32'(done_err), 32'(exp_err));
    chk({tag, ".aw_hs"}, 32'(aw_hs), exp_traffic ? 32'd1 : 32'd0);
    chk({tag, ".w_beats"}, 32'(w_beats), exp_traffic ? 32'(int'(len) + 1) : 32'd0);
    if (!exp_traffic) chk({tag, ".no_traffic"}, 32'(traffic), 32'd0);
    @(negedge clk);
    #1 chk({tag, ".done_pulse"}, 32'({done, cmd_ready}), 32'b01);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                         input int last_idx, input logic [31:0] data0, input logic [1:0] resp,
                         input bit exp_err, input bit exp_traffic);
    int ar_hs = 0, r_beats = 0, cyc = 0;
    bit r_active = 0, got_done = 0, done_err = 0, traffic = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
    #1 chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!got_done && cyc < 300) begin
      arready  = 1'b1;
      rd_ready = 1'b1;
      rvalid   = r_active;
      rdata    = data0 + 32'(r_beats);
      rlast    = r_active && (r_beats == last_idx);
      rresp    = resp;
      rid      = '0;
      #1;
      if (awvalid || arvalid || wvalid) traffic = 1;
      if (rvalid && rready) begin
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, ".rd_data"}, rd_data, data0 + 32'(r_beats));
        chk({tag, ".rd_last"}, 32'(rd_last), 32'(r_beats == last_idx));
        if (r_beats == last_idx) r_active = 0;
        r_beats++;
      end
      if (arvalid) begin
        chk({tag, ".araddr"}, araddr, addr);
        chk({tag, ".ar_fields"}, 32'({arid, arlen, arsize, arburst}),
            32'({4'd0, len, 3'b010, 2'b01}));
        ar_hs++;
        r_active = 1;
      end
      if (done) begin got_done = 1; done_err = err; end
      cyc++;
      if (!got_done) @(negedge clk);
    end
    idle_inputs();
    chk({tag, ".done_seen"}, 32'(got_done), 32'd1);
    chk({tag, ".err"}, 32'(done_err), 32'(exp_err));
    chk({tag, ".ar_hs"}, 32'(ar_hs), exp_traffic ? 32'd1 : 32'd0);
    chk({tag, ".r_beats"}, 32'(r_beats), exp_traffic ? 32'(last_idx + 1) : 32'd0);
    if (!exp_traffic) chk({tag, ".no_traffic"}, 32'(traffic), 32'd0);
    @(negedge clk);
    #1 chk({tag, ".done_pulse"}, 32'({done, rd_valid, cmd_ready}), 32'b001);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs",
           32'({awvalid, wvalid, arvalid, bready, rready, wr_ready, rd_valid, done, err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);

    do_write("wr_basic",     32'h0000_1000, 8'd3, 0, 1'b0, 2'b00, 1'b0, 1'b1);
    do_read ("rd_single",    32'h0000_2000, 8'd0, 0, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b1);
    do_write("wr_stall",     32'h0000_1100, 8'd5, 5, 1'b1, 2'b00, 1'b0, 1'b1);
    do_write("wr_4k_cross",  32'h0000_0FF8, 8'd3, 0, 1'b0, 2'b00, 1'b1, 1'b0);
    do_read ("rd_4k_cross",  32'h0000_0FF8, 8'd3, 3, 32'h0, 2'b00, 1'b1, 1'b0);
    do_write("wr_misalign",  32'h0000_1002, 8'd0, 0, 1'b0, 2'b00, 1'b1, 1'b0);
    do_read ("rd_misalign",  32'h0000_1002, 8'd0, 0, 32'h0, 2'b00, 1'b1, 1'b0);
    do_write("wr_4k_edge",   32'h0000_0FF0, 8'd3, 0, 1'b0, 2'b00, 1'b0, 1'b1);
    do_write("wr_bresp",     32'h0000_1200, 8'd1, 0, 1'b0, 2'b10, 1'b1, 1'b1);
    do_read ("rd_early_last",32'h0000_2100, 8'd3, 1, 32'h0000_0100, 2'b00, 1'b1, 1'b1);
    do_read ("rd_multi",     32'h0000_2200, 8'd3, 3, 32'h0000_0200, 2'b00, 1'b0, 1'b1);

    // Reset in the middle of a write burst.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_3000; cmd_len = 8'd7;
    @(negedge clk);
    cmd_valid = 1'b0; awready = 1'b1; wr_valid = 1'b1; wready = 1'b1; wr_data = 32'h55;
    @(negedge clk);
    #1 chk("rst_mid.in_wr_data", 32'(wvalid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_mid.outputs_low",
           32'({awvalid, wvalid, arvalid, bready, rready, wr_ready, rd_valid, done, err}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("rst_mid.no_done_in_reset", 32'(done), 32'd0);
    end
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("rst_mid.after_release", 32'({done, cmd_ready}), 32'b01);
    do_read("rd_post_rst", 32'h0000_4000, 8'd0, 0, 32'h1234_5678, 2'b00, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
